// File: rtl/sprite_compositor.sv
// Sprite compositor: time-multiplexes per-layer sprite ROM reads within one pixel period
// and publishes the highest-priority non-transparent colour one pixel period later.
module sprite_compositor #(
    parameter int                NUM_LAYERS = 3,
    parameter int                ADDR_W     = 17,
    parameter int                PIX_W      = 12,
    parameter int                PIX_DIV    = 4,
    parameter logic [PIX_W-1:0]  KEY_COLOR  = 12'h0F0,
    parameter logic [PIX_W-1:0]  BG_COLOR   = 12'h000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pix_stb,
    input  logic                         valid_in,
    input  logic                         hsync_in,
    input  logic                         vsync_in,
    input  logic [NUM_LAYERS-1:0]        layer_en,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [PIX_W-1:0]             rom_data,
    output logic [PIX_W-1:0]             pixel_out,
    output logic                         hsync_out,
    output logic                         vsync_out,
    output logic                         overrun
);
    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int CNT_W = $clog2(PIX_DIV) + 1;
    // Reads issued past this count cannot return before the next strobe.
    localparam logic [CNT_W-1:0] BUDGET = CNT_W'(PIX_DIV - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_LAYERS-1:0] m);
        lowest_idx = {IDX_W{1'b0}};
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (m[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    function automatic logic [NUM_LAYERS-1:0] clear_lowest(input logic [NUM_LAYERS-1:0] m);
        return m & (m - NUM_LAYERS'(1));
    endfunction

    state_t                      state_q;
    logic [PIX_W-1:0]            pixel_q, res_q;
    logic                        hs_out_q, vs_out_q, snap_hs_q, snap_vs_q, overrun_q;
    logic [NUM_LAYERS-1:0]       rem_q;
    logic [NUM_LAYERS*ADDR_W-1:0] snap_addr_q;
    logic [ADDR_W-1:0]           rom_addr_q;
    logic                        iss_v_q, iss_last_q, lat_v_q, lat_last_q;
    logic [CNT_W-1:0]            iss_cnt_q;

    logic                        start_s, hit_s, all_key_s, can_issue_s, overrun_now_s;
    logic [IDX_W-1:0]            first_idx_s, next_idx_s;
    logic [PIX_W-1:0]            pixel_d;

    // Scan decisions and the value to publish if this edge is a strobe.
    always_comb begin
        start_s       = valid_in && (|layer_en);
        first_idx_s   = lowest_idx(layer_en);
        next_idx_s    = lowest_idx(rem_q);
        hit_s         = (state_q == SCAN) && lat_v_q && (rom_data != KEY_COLOR);
        all_key_s     = (state_q == SCAN) && lat_v_q && (rom_data == KEY_COLOR) && lat_last_q;
        can_issue_s   = (state_q == SCAN) && (|rem_q) && (iss_cnt_q < BUDGET) && !hit_s && !all_key_s;
        overrun_now_s = (state_q == SCAN) && !hit_s && !all_key_s;
        if (hit_s) begin
            pixel_d = rom_data;
        end else if (state_q == SCAN) begin
            pixel_d = BG_COLOR;
        end else begin
            pixel_d = res_q;
        end
    end

    // Pixel-period FSM, ROM address issue, read pipeline and output publish.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pixel_q     <= {PIX_W{1'b0}};
            res_q       <= {PIX_W{1'b0}};
            hs_out_q    <= 1'b1;
            vs_out_q    <= 1'b1;
            snap_hs_q   <= 1'b1;
            snap_vs_q   <= 1'b1;
            overrun_q   <= 1'b0;
            rem_q       <= {NUM_LAYERS{1'b0}};
            snap_addr_q <= {(NUM_LAYERS*ADDR_W){1'b0}};
            rom_addr_q  <= {ADDR_W{1'b0}};
            iss_v_q     <= 1'b0;
            iss_last_q  <= 1'b0;
            lat_v_q     <= 1'b0;
            lat_last_q  <= 1'b0;
            iss_cnt_q   <= {CNT_W{1'b0}};
        end else if (pix_stb) begin
            pixel_q     <= pixel_d;
            hs_out_q    <= snap_hs_q;
            vs_out_q    <= snap_vs_q;
            if (overrun_now_s) overrun_q <= 1'b1;
            snap_hs_q   <= hsync_in;
            snap_vs_q   <= vsync_in;
            snap_addr_q <= layer_addr;
            res_q       <= valid_in ? BG_COLOR : {PIX_W{1'b0}};
            // Reads still in flight belong to the previous pixel and are dropped.
            lat_v_q     <= 1'b0;
            lat_last_q  <= 1'b0;
            iss_v_q     <= start_s;
            iss_last_q  <= start_s && (clear_lowest(layer_en) == {NUM_LAYERS{1'b0}});
            if (start_s) begin
                state_q    <= SCAN;
                rom_addr_q <= layer_addr[first_idx_s*ADDR_W +: ADDR_W];
                rem_q      <= clear_lowest(layer_en);
                iss_cnt_q  <= CNT_W'(1);
            end else begin
                state_q    <= IDLE;
                rem_q      <= {NUM_LAYERS{1'b0}};
                iss_cnt_q  <= {CNT_W{1'b0}};
            end
        end else begin
            lat_v_q    <= iss_v_q;
            lat_last_q <= iss_last_q;
            iss_v_q    <= can_issue_s;
            iss_last_q <= can_issue_s && (clear_lowest(rem_q) == {NUM_LAYERS{1'b0}});
            if (can_issue_s) begin
                rom_addr_q <= snap_addr_q[next_idx_s*ADDR_W +: ADDR_W];
                rem_q      <= clear_lowest(rem_q);
                iss_cnt_q  <= iss_cnt_q + CNT_W'(1);
            end
            if (hit_s) begin
                res_q   <= rom_data;
                state_q <= DONE;
            end else if (all_key_s) begin
                res_q   <= BG_COLOR;
                state_q <= DONE;
            end
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pixel_out = pixel_q;
    assign hsync_out = hs_out_q;
    assign vsync_out = vs_out_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: priority, skipping, transparency, sync alignment,
// reset mid-scan and overrun on a 4-layer instance.
module tb_sprite_compositor;
    logic        clk = 1'b0;
    logic        rst_n, pix_stb, valid_in, hsync_in, vsync_in;
    logic [2:0]  layer_en;
    logic [50:0] layer_addr;
    logic [16:0] rom_addr;
    logic [11:0] rom_data, pixel_out;
    logic        hsync_out, vsync_out, overrun;
    logic [3:0]  layer_en4;
    logic [67:0] layer_addr4;
    logic [16:0] rom_addr4;
    logic [11:0] rom_data4, pixel_out4;
    logic        hsync_out4, vsync_out4, overrun4;

    logic [11:0] rom [16];
    int checks = 0;
    int failures = 0;
    logic [11:0] pub_pix;
    logic        pub_hs, pub_vs;
    logic [16:0] addr_e0;
    logic [15:0] seen;

    always #5 clk = ~clk;

    sprite_compositor dut (
        .clk(clk), .rst_n(rst_n), .pix_stb(pix_stb), .valid_in(valid_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .layer_en(layer_en),
        .layer_addr(layer_addr), .rom_addr(rom_addr), .rom_data(rom_data),
        .pixel_out(pixel_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .overrun(overrun)
    );

    sprite_compositor #(.NUM_LAYERS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .pix_stb(pix_stb), .valid_in(valid_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .layer_en(layer_en4),
        .layer_addr(layer_addr4), .rom_addr(rom_addr4), .rom_data(rom_data4),
        .pixel_out(pixel_out4), .hsync_out(hsync_out4), .vsync_out(vsync_out4),
        .overrun(overrun4)
    );

    // Synchronous sprite ROMs with one cycle of latency.
    always @(posedge clk) begin
        rom_data  <= rom[rom_addr[3:0]];
        rom_data4 <= rom[rom_addr4[3:0]];
    end

    task automatic run_pixel(input logic v, input logic hs, input logic vs, input logic [2:0] en,
                             input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        valid_in   = v;
        hsync_in   = hs;
        vsync_in   = vs;
        layer_en   = en;
        layer_addr = {13'd0, a2, 13'd0, a1, 13'd0, a0};
        pix_stb    = 1'b1;
        @(posedge clk);
        #1;
        pix_stb = 1'b0;
        pub_pix = pixel_out;
        pub_hs  = hsync_out;
        pub_vs  = vsync_out;
        addr_e0 = rom_addr;
        seen    = 16'h0000;
        seen[rom_addr[3:0]] = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            seen[rom_addr[3:0]] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        layer_en = 3'b111; layer_addr = {17'd1, 17'd2, 17'd4};
        layer_en4 = 4'b0000; layer_addr4 = 68'd0;
        pix_stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix_stb = ~pix_stb;
            @(posedge clk);
            #1;
        end
        pix_stb = 1'b0;
        rst_n = 1'b1;
        checks += 6;
        if (pixel_out !== 12'h000) begin failures++; $display("FAIL reset_pixel got=%h exp=000", pixel_out); end
        if (hsync_out !== 1'b1) begin failures++; $display("FAIL reset_hsync got=%b exp=1", hsync_out); end
        if (vsync_out !== 1'b1) begin failures++; $display("FAIL reset_vsync got=%b exp=1", vsync_out); end
        if (rom_addr !== 17'd0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
        if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        if (overrun4 !== 1'b0) begin failures++; $display("FAIL reset_overrun4 got=%b exp=0", overrun4); end
    endtask

    task automatic test_priority();
        run_pixel(1'b1, 1'b1, 1'b1, 3'b011, 4'd1, 4'd2, 4'd8);
        checks++;
        if (addr_e0 !== 17'd1) begin failures++; $display("FAIL prio_first_addr got=%h exp=1", addr_e0); end
        run_pixel(1'b1, 1'b1, 1'b1, 3'b000, 4'd9, 4'd9, 4'd9);
        checks += 3;
        if (pub_pix !== 12'hF00) begin failures++; $display("FAIL prio_pixel got=%h exp=F00", pub_pix); end
        if (addr_e0 !== 17'd2) begin failures++; $display("FAIL noen_addr_hold got=%h exp=2", addr_e0); end
        if (seen !== 16'h0004) begin failures++; $display("FAIL noen_no_reads got=%h exp=0004", seen); end
    endtask

    task automatic test_skip();
        run_pixel(1'b1, 1'b1, 1'b1, 3'b101, 4'd3, 4'd2, 4'd4);
        checks += 2;
        if (pub_pix !== 12'h000) begin failures++; $display("FAIL noen_pixel got=%h exp=000", pub_pix); end
        if (seen !== 16'h0018) begin failures++; $display("FAIL skip_addrs got=%h exp=0018", seen); end
        run_pixel(1'b0, 1'b1, 1'b1, 3'b111, 4'd1, 4'd2, 4'd8);
        checks += 2;
        if (pub_pix !== 12'h00F) begin failures++; $display("FAIL skip_pixel got=%h exp=00F", pub_pix); end
        if (seen !== 16'h0010) begin failures++; $display("FAIL invalid_no_reads got=%h exp=0010", seen); end
    endtask

    task automatic test_transparent();
        run_pixel(1'b1, 1'b1, 1'b1, 3'b111, 4'd3, 4'd5, 4'd6);
        checks++;
        if (pub_pix !== 12'h000) begin failures++; $display("FAIL invalid_pixel got=%h exp=000", pub_pix); end
        run_pixel(1'b1, 1'b1, 1'b1, 3'b100, 4'd9, 4'd9, 4'd2);
        checks++;
        if (pub_pix !== 12'h000) begin failures++; $display("FAIL allkey_pixel got=%h exp=000", pub_pix); end
        run_pixel(1'b1, 1'b1, 1'b1, 3'b000, 4'd9, 4'd9, 4'd9);
        checks++;
        if (pub_pix !== 12'h0AB) begin failures++; $display("FAIL layer2_only got=%h exp=0AB", pub_pix); end
    endtask

    task automatic test_sync_align();
        logic        hs_prev, vs_prev;
        logic [11:0] col_prev;
        hs_prev = 1'b1; vs_prev = 1'b1; col_prev = 12'h000;
        for (int i = 0; i < 12; i++) begin
            logic hs, vs;
            logic [3:0] a;
            hs = !(i >= 4 && i <= 8);
            vs = (i != 6);
            a  = (i % 2 == 1) ? 4'd1 : 4'd8;
            run_pixel(1'b1, hs, vs, 3'b001, a, 4'd3, 4'd3);
            if (i > 0) begin
                checks += 3;
                if (pub_hs !== hs_prev) begin failures++; $display("FAIL sync_hs[%0d] got=%b exp=%b", i, pub_hs, hs_prev); end
                if (pub_vs !== vs_prev) begin failures++; $display("FAIL sync_vs[%0d] got=%b exp=%b", i, pub_vs, vs_prev); end
                if (pub_pix !== col_prev) begin failures++; $display("FAIL sync_pix[%0d] got=%h exp=%h", i, pub_pix, col_prev); end
            end
            hs_prev  = hs;
            vs_prev  = vs;
            col_prev = (a == 4'd1) ? 12'hF00 : 12'h123;
        end
    endtask

    task automatic test_reset_mid_scan();
        valid_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        layer_en = 3'b001; layer_addr = {17'd0, 17'd0, 17'd1};
        pix_stb = 1'b1;
        @(posedge clk);
        #1;
        pix_stb = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks += 4;
        if (pixel_out !== 12'h000) begin failures++; $display("FAIL midrst_pixel got=%h exp=000", pixel_out); end
        if (hsync_out !== 1'b1) begin failures++; $display("FAIL midrst_hsync got=%b exp=1", hsync_out); end
        if (vsync_out !== 1'b1) begin failures++; $display("FAIL midrst_vsync got=%b exp=1", vsync_out); end
        if (rom_addr !== 17'd0) begin failures++; $display("FAIL midrst_rom_addr got=%h exp=0", rom_addr); end
        repeat (2) @(posedge clk);
        #1;
        run_pixel(1'b1, 1'b1, 1'b1, 3'b001, 4'd8, 4'd3, 4'd3);
        checks += 2;
        if (pub_pix !== 12'h000) begin failures++; $display("FAIL midrst_discard got=%h exp=000", pub_pix); end
        if (pub_hs !== 1'b1) begin failures++; $display("FAIL midrst_discard_hs got=%b exp=1", pub_hs); end
        run_pixel(1'b1, 1'b1, 1'b1, 3'b000, 4'd9, 4'd9, 4'd9);
        checks++;
        if (pub_pix !== 12'h123) begin failures++; $display("FAIL midrst_rescan got=%h exp=123", pub_pix); end
    endtask

    task automatic test_overrun();
        layer_en4   = 4'b1111;
        layer_addr4 = {17'd8, 17'd6, 17'd5, 17'd3};
        run_pixel(1'b1, 1'b1, 1'b1, 3'b000, 4'd9, 4'd9, 4'd9);
        layer_en4 = 4'b0000;
        checks++;
        if (overrun4 !== 1'b0) begin failures++; $display("FAIL overrun_early got=%b exp=0", overrun4); end
        run_pixel(1'b1, 1'b1, 1'b1, 3'b000, 4'd9, 4'd9, 4'd9);
        checks += 3;
        if (pixel_out4 !== 12'h000) begin failures++; $display("FAIL overrun_pixel got=%h exp=000", pixel_out4); end
        if (overrun4 !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", overrun4); end
        if (overrun !== 1'b0) begin failures++; $display("FAIL no_overrun_3layer got=%b exp=0", overrun); end
        run_pixel(1'b1, 1'b1, 1'b1, 3'b000, 4'd9, 4'd9, 4'd9);
        checks++;
        if (overrun4 !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", overrun4); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 12'h0F0;
        rom[1] = 12'hF00;
        rom[2] = 12'h0AB;
        rom[4] = 12'h00F;
        rom[8] = 12'h123;
        test_reset();
        test_priority();
        test_skip();
        test_transparent();
        test_sync_align();
        test_reset_mid_scan();
        test_overrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
